// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order tracker of in-flight predicted branches.
// Fetch pushes {index, taken, target, pc}; execute resolves the oldest entry and
// a registered update bundle for the gshare predictor is produced one cycle later,
// together with a mispredict redirect when the prediction was wrong.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync queue discard)
//   push_*  : prediction input from fetch, push_ready_o back-pressure
//   exe_*   : resolution of the oldest branch, exe_ready_o when non-empty
//   res_*   : one-cycle predictor update pulse (index, actual direction)
//   mispredict_o / redirect_pc_o : one-cycle redirect pulse to the frontend

package mmm_pkg;
   localparam int XLEN = 32;
   localparam int HLEN = 8;
endpackage

module branch_resolve_queue
   import mmm_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            push_valid_i,
   output logic            push_ready_o,
   input  logic [HLEN-1:0] push_index_i,
   input  logic            push_taken_i,
   input  logic [XLEN-1:0] push_target_i,
   input  logic [XLEN-1:0] push_pc_i,
   input  logic            exe_valid_i,
   output logic            exe_ready_o,
   input  logic            exe_taken_i,
   input  logic [XLEN-1:0] exe_target_i,
   output logic            res_valid_o,
   output logic [HLEN-1:0] res_index_o,
   output logic            res_taken_o,
   output logic            mispredict_o,
   output logic [XLEN-1:0] redirect_pc_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [0:0] RUN = 1'b0;
   localparam logic [0:0] RECOVER = 1'b1;

   logic [HLEN-1:0] r_index  [DEPTH];
   logic            r_taken  [DEPTH];
   logic [XLEN-1:0] r_target [DEPTH];
   logic [XLEN-1:0] r_pc     [DEPTH];
   logic [PW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_count;
   logic [0:0]      r_state;
   logic            r_res_valid, r_res_taken, r_mispredict;
   logic [HLEN-1:0] r_res_index;
   logic [XLEN-1:0] r_redirect;
   logic            w_push_fire, w_exe_fire, w_wrong;
   logic [XLEN-1:0] w_redirect;

   // Pushes are refused when full even if a pop fires in the same cycle,
   // and during the single RECOVER cycle so wrong-path fetches are dropped.
   assign push_ready_o = !rst_i && r_state == RUN && r_count < FULL;
   assign exe_ready_o  = !rst_i && r_count != '0;
   assign w_push_fire  = push_valid_i && push_ready_o;
   assign w_exe_fire   = exe_valid_i && exe_ready_o;
   // Target only matters when the branch was actually taken.
   assign w_wrong      = (r_taken[r_rptr] != exe_taken_i) ||
                         (exe_taken_i && r_target[r_rptr] != exe_target_i);
   assign w_redirect   = exe_taken_i ? exe_target_i : r_pc[r_rptr] + XLEN'(4);

   assign res_valid_o   = r_res_valid;
   assign res_index_o   = r_res_index;
   assign res_taken_o   = r_res_taken;
   assign mispredict_o  = r_mispredict;
   assign redirect_pc_o = r_redirect;

   // Entry storage needs no reset: pointers and count define what is live.
   always_ff @(posedge clk_i) begin
      if (w_push_fire) begin
         r_index[r_wptr]  <= push_index_i;
         r_taken[r_wptr]  <= push_taken_i;
         r_target[r_wptr] <= push_target_i;
         r_pc[r_wptr]     <= push_pc_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_state      <= RUN;
         r_res_valid  <= 1'b0;
         r_res_index  <= '0;
         r_res_taken  <= 1'b0;
         r_mispredict <= 1'b0;
         r_redirect   <= '0;
      end else if (flush_i) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_state      <= RUN;
         r_res_valid  <= 1'b0;
         r_mispredict <= 1'b0;
      end else begin
         r_res_valid  <= w_exe_fire;
         r_mispredict <= w_exe_fire && w_wrong;
         r_state      <= (w_exe_fire && w_wrong) ? RECOVER : RUN;
         if (w_exe_fire) begin
            r_res_index <= r_index[r_rptr];
            r_res_taken <= exe_taken_i;
            r_redirect  <= w_redirect;
         end
         // A mispredict squashes every younger entry, including a same-cycle push.
         if (w_exe_fire && w_wrong) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push_fire) r_wptr <= r_wptr + PW'(1);
            if (w_exe_fire) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push_fire) - CW'(w_exe_fire);
         end
      end
   end
endmodule
